ahbl_slave_mem: RTL and testbench

AHB-Lite subordinate (slave) with an internal word-addressed memory, configurable wait states and protocol-correct two-cycle ERROR responses. It is the responder end of the AHB-Lite bus driven by the testbench master agent. It serves as the DUT-side target for the master driver and monitor, and as a reusable scoreboard-checkable memory model.

---
 rtl/ahbl_slave_mem.sv | 150 +++++++++++++++
 tb/tb_ahbl_slave_mem.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ahbl_slave_mem.sv
// AHB-Lite subordinate backed by a word-addressed memory with optional wait
// states on OKAY transfers and a two-cycle ERROR response for bad requests.
module ahbl_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [1:0]            HTRANS,
    input  logic [3:0]            HPROT,
    input  logic                  HMAST_LOCK,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int LAT_W = IDX_W + 2;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(4 * MEM_DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [LAT_W-1:0]        addr_q, addr_d;
    logic                    write_q, write_d;
    logic [1:0]              size_q, size_d;
    logic                    hreadyout_q, hreadyout_d;
    logic                    hresp_q, hresp_d;

    logic                    accept;
    logic                    req_err;
    logic [3:0]              be;
    logic [IDX_W-1:0]        widx;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    // Sideband fields carry no meaning for a plain memory target.
    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HMAST_LOCK, HTRANS[0]};

    assign accept = HSEL & HREADY & HTRANS[1];
    assign widx   = addr_q[LAT_W-1:2];

    always_comb begin
        req_err = 1'b0;
        if ({1'b0, HADDR} >= LIMIT)                  req_err = 1'b1;
        if (HSIZE > 3'd2)                            req_err = 1'b1;
        if (HSIZE == 3'd1 && HADDR[0])               req_err = 1'b1;
        if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)    req_err = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == WS) begin
                    state_d = S_DATA;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all present HREADYOUT=1, so the next
                // address phase can be taken here.
                if (accept) begin
                    addr_d  = HADDR[LAT_W-1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE[1:0];
                    if (req_err) begin
                        state_d = S_ERR1;
                    end else if (WS != 4'd0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'd1;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
        hreadyout_d = !(state_d == S_WAIT || state_d == S_ERR1);
        hresp_d     = (state_d == S_ERR1 || state_d == S_ERR2);
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= 2'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    always_comb begin
        be = 4'b0000;
        case (size_q)
            2'd0:    be[addr_q[1:0]] = 1'b1;
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Memory is deliberately left out of reset; a reset edge only blocks the commit.
    always_ff @(posedge HCLK) begin
        if (HRESETn && state_q == S_DATA && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = (state_q == S_DATA && !write_q) ? mem[widx] : '0;

endmodule

// File: tb/tb_ahbl_slave_mem.sv
// Directed bench: one zero-wait and one three-wait-state instance share the
// master signals; HSEL steers each transfer to the instance under test.
module tb_ahbl_slave_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic [1:0]  htrans = 2'b00;
    logic [31:0] hwdata = '0;
    logic        which = 1'b0;

    logic        ro0, rs0, ro3, rs3;
    logic [31:0] rd0, rd3;
    logic        rdy, resp;
    logic [31:0] rdata;

    int pass = 0;
    int total = 0;

    always #5 clk = ~clk;

    assign rdy   = which ? ro3 : ro0;
    assign resp  = which ? rs3 : rs0;
    assign rdata = which ? rd3 : rd0;

    ahbl_slave_mem #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & ~which), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HTRANS(htrans),
        .HPROT(4'd0), .HMAST_LOCK(1'b0), .HWDATA(hwdata), .HREADY(ro0),
        .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0));

    ahbl_slave_mem #(.WAIT_STATES(3)) u_dut3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & which), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HTRANS(htrans),
        .HPROT(4'd0), .HMAST_LOCK(1'b0), .HWDATA(hwdata), .HREADY(ro3),
        .HREADYOUT(ro3), .HRESP(rs3), .HRDATA(rd3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single non-pipelined transfer; data-phase wait cycles are bounded.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output int nlow, output logic r_first, output logic r_last);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
        tick();
        htrans = 2'b00; hwdata = wd; nlow = 0; r_first = resp;
        while (!rdy && nlow < 20) begin
            nlow++;
            tick();
        end
        rd = rdata; r_last = resp;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        for (int w = 0; w < 2; w++) begin
            which = w[0];
            #0;
            total++; if (rdy !== 1'b1) $display("FAIL reset_rdy%0d got %b want 1", w, rdy); else pass++;
            total++; if (resp !== 1'b0) $display("FAIL reset_resp%0d got %b want 0", w, resp); else pass++;
            total++; if (rdata !== 32'h0) $display("FAIL reset_rdata%0d got %h want 0", w, rdata); else pass++;
        end
        rst_n = 1'b1; which = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        which = 1'b0;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
        tick();
        total++; if (rdy !== 1'b1 || resp !== 1'b0) $display("FAIL b2b_wr_phase got rdy=%b resp=%b want 1/0", rdy, resp); else pass++;
        hwdata = 32'hDEADBEEF; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b0;
        tick();
        total++; if (rdy !== 1'b1) $display("FAIL b2b_rd_rdy got %b want 1", rdy); else pass++;
        total++; if (resp !== 1'b0) $display("FAIL b2b_rd_resp got %b want 0", resp); else pass++;
        total++; if (rdata !== 32'hDEADBEEF) $display("FAIL b2b_rd_data got %h want deadbeef", rdata); else pass++;
        htrans = 2'b00;
        tick();
        total++; if (rdata !== 32'h0) $display("FAIL b2b_idle_rdata got %h want 0", rdata); else pass++;
        total++; if (rdy !== 1'b1) $display("FAIL b2b_idle_rdy got %b want 1", rdy); else pass++;
    endtask

    task automatic test_subword();
        logic [31:0] rd; int nl; logic rf, rl;
        which = 1'b0;
        xfer(1'b1, 32'h20, 3'd2, 32'h00000000, rd, nl, rf, rl);
        xfer(1'b1, 32'h22, 3'd0, 32'h00AA0000, rd, nl, rf, rl);
        xfer(1'b1, 32'h20, 3'd1, 32'h00001234, rd, nl, rf, rl);
        xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, nl, rf, rl);
        total++; if (rd !== 32'h00AA1234) $display("FAIL subword_read got %h want 00aa1234", rd); else pass++;
        total++; if (nl !== 0) $display("FAIL subword_waits got %0d want 0", nl); else pass++;
        xfer(1'b1, 32'h21, 3'd0, 32'h00005A00, rd, nl, rf, rl);
        xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, nl, rf, rl);
        total++; if (rd !== 32'h00AA5A34) $display("FAIL subword_byte1 got %h want 00aa5a34", rd); else pass++;
    endtask

    task automatic test_idle_busy();
        logic [31:0] rd; int nl; logic rf, rl;
        which = 1'b0;
        xfer(1'b1, 32'h40, 3'd2, 32'h0BADF00D, rd, nl, rf, rl);
        hsel = 1'b1; htrans = 2'b00; hwrite = 1'b1; haddr = 32'h40; hsize = 3'd2;
        tick();
        hwdata = 32'hFFFFFFFF;
        total++; if (rdy !== 1'b1 || resp !== 1'b0) $display("FAIL idle_sel got rdy=%b resp=%b want 1/0", rdy, resp); else pass++;
        htrans = 2'b01;
        tick();
        total++; if (rdy !== 1'b1 || resp !== 1'b0) $display("FAIL busy_sel got rdy=%b resp=%b want 1/0", rdy, resp); else pass++;
        hsel = 1'b0; htrans = 2'b10;
        tick();
        total++; if (rdy !== 1'b1 || resp !== 1'b0) $display("FAIL nonseq_unsel got rdy=%b resp=%b want 1/0", rdy, resp); else pass++;
        hsel = 1'b1; htrans = 2'b00;
        tick();
        xfer(1'b0, 32'h40, 3'd2, 32'h0, rd, nl, rf, rl);
        total++; if (rd !== 32'h0BADF00D) $display("FAIL idle_mem got %h want 0badf00d", rd); else pass++;
    endtask

    task automatic test_wait();
        logic [31:0] rd; int nl; logic rf, rl;
        which = 1'b1;
        xfer(1'b1, 32'h04, 3'd2, 32'hCAFEF00D, rd, nl, rf, rl);
        total++; if (nl !== 3) $display("FAIL wait_wr_cycles got %0d want 3", nl); else pass++;
        xfer(1'b0, 32'h04, 3'd2, 32'h0, rd, nl, rf, rl);
        total++; if (nl !== 3) $display("FAIL wait_rd_cycles got %0d want 3", nl); else pass++;
        total++; if (rd !== 32'hCAFEF00D) $display("FAIL wait_rd_data got %h want cafef00d", rd); else pass++;
        total++; if (rf !== 1'b0 || rl !== 1'b0) $display("FAIL wait_resp got %b%b want 00", rf, rl); else pass++;
        xfer(1'b1, 32'h3FC, 3'd2, 32'h13579BDF, rd, nl, rf, rl);
        xfer(1'b0, 32'h3FC, 3'd2, 32'h0, rd, nl, rf, rl);
        total++; if (rd !== 32'h13579BDF || rl !== 1'b0) $display("FAIL last_word got %h/%b want 13579bdf/0", rd, rl); else pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; int nl; logic rf, rl;
        which = 1'b1;
        xfer(1'b1, 32'h00, 3'd2, 32'h11223344, rd, nl, rf, rl);
        xfer(1'b0, 32'h400, 3'd2, 32'h0, rd, nl, rf, rl);
        total++; if (nl !== 1 || rf !== 1'b1 || rl !== 1'b1) $display("FAIL err_range got low=%0d resp=%b%b want 1/11", nl, rf, rl); else pass++;
        total++; if (rd !== 32'h0) $display("FAIL err_range_rdata got %h want 0", rd); else pass++;
        xfer(1'b1, 32'h02, 3'd2, 32'hFFFFFFFF, rd, nl, rf, rl);
        total++; if (nl !== 1 || rf !== 1'b1 || rl !== 1'b1) $display("FAIL err_align_w got low=%0d resp=%b%b want 1/11", nl, rf, rl); else pass++;
        xfer(1'b1, 32'h01, 3'd1, 32'hFFFFFFFF, rd, nl, rf, rl);
        total++; if (nl !== 1 || rf !== 1'b1 || rl !== 1'b1) $display("FAIL err_align_h got low=%0d resp=%b%b want 1/11", nl, rf, rl); else pass++;
        xfer(1'b1, 32'h00, 3'd3, 32'hFFFFFFFF, rd, nl, rf, rl);
        total++; if (nl !== 1 || rf !== 1'b1 || rl !== 1'b1) $display("FAIL err_size got low=%0d resp=%b%b want 1/11", nl, rf, rl); else pass++;
        xfer(1'b0, 32'h00, 3'd2, 32'h0, rd, nl, rf, rl);
        total++; if (rd !== 32'h11223344) $display("FAIL err_nowrite got %h want 11223344", rd); else pass++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; int nl; logic rf, rl;
        which = 1'b1;
        xfer(1'b1, 32'h30, 3'd2, 32'h600DD00D, rd, nl, rf, rl);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2;
        tick();
        htrans = 2'b00; hwdata = 32'hBAD0BAD0;
        total++; if (rdy !== 1'b0) $display("FAIL abort_wait1 got %b want 0", rdy); else pass++;
        tick();
        total++; if (rdy !== 1'b0) $display("FAIL abort_wait2 got %b want 0", rdy); else pass++;
        rst_n = 1'b0;
        tick();
        total++; if (rdy !== 1'b1 || resp !== 1'b0 || rdata !== 32'h0) $display("FAIL abort_reset got rdy=%b resp=%b data=%h want 1/0/0", rdy, resp, rdata); else pass++;
        rst_n = 1'b1;
        tick();
        xfer(1'b0, 32'h30, 3'd2, 32'h0, rd, nl, rf, rl);
        total++; if (rd !== 32'h600DD00D) $display("FAIL abort_mem got %h want 600dd00d", rd); else pass++;
    endtask

    initial begin
        #1;
        test_reset();
        test_back_to_back();
        test_subword();
        test_idle_busy();
        test_wait();
        test_errors();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
